// File: rtl/tge_ss_pkg.sv
// Shared definitions for the 10GbE TX snapshot sequencer: FSM states,
// control-word bit indices and status-word bit positions.
package tge_ss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } ss_state_e;

  localparam int CTRL_ARM       = 0;
  localparam int CTRL_TRIG_SEL  = 1;
  localparam int CTRL_VALID_SEL = 2;
  localparam int CTRL_ABORT     = 3;

  localparam int STAT_DONE      = 31;
  localparam int STAT_ARMED     = 30;
  localparam int STAT_CAPTURING = 29;

endpackage

// File: rtl/tge_ss_edge_det.sv
// One-bit rising-edge detector. RST_VAL sets the reset value of the
// previous-value register, so a level held through reset can be masked.
module tge_ss_edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= RST_VAL;
    else        r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/tge_tx_snapshot_ctrl.sv
// Snapshot buffer sequencer: arms on a control-word edge, waits for a trigger,
// streams qualified TX words into the capture BRAM and reports status.
module tge_tx_snapshot_ctrl
  import tge_ss_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl_word,
  input  logic              trig,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic [31:0]       status_word
);

  localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

  ss_state_e         r_state, w_state_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_status, w_status_nxt;
  logic              w_arm_edge, w_abort, w_go, w_qualify, w_we_nxt;

  // Previous arm bit resets high so an arm level held through reset is not an edge.
  tge_ss_edge_det #(.RST_VAL(1'b1)) u_arm_edge (
    .clk    (user_clk),
    .rst_n  (user_rst_n),
    .i_d    (ctrl_word[CTRL_ARM]),
    .o_rise (w_arm_edge)
  );

  assign w_abort   = ctrl_word[CTRL_ABORT];
  assign w_go      = ctrl_word[CTRL_TRIG_SEL] | trig;
  assign w_qualify = ctrl_word[CTRL_VALID_SEL] | din_valid;

  // NOTE: every signal written here gets a default first, so no path through
  // the branches can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_we_nxt    = 1'b0;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else if (w_arm_edge && (r_state != ST_CAPTURE)) begin
      w_state_nxt = ST_ARMED;
      w_count_nxt = '0;
    end else if ((r_state == ST_CAPTURE) || ((r_state == ST_ARMED) && w_go)) begin
      // The trigger cycle itself is the first candidate capture cycle.
      w_state_nxt = ST_CAPTURE;
      if (w_qualify) begin
        w_we_nxt    = 1'b1;
        w_count_nxt = r_count + 1'b1;
        if (r_count == LAST_ADDR) w_state_nxt = ST_DONE;
      end
    end
  end

  always_comb begin
    w_status_nxt                 = '0;
    w_status_nxt[STAT_DONE]      = (w_state_nxt == ST_DONE);
    w_status_nxt[STAT_ARMED]     = (w_state_nxt == ST_ARMED);
    w_status_nxt[STAT_CAPTURING] = (w_state_nxt == ST_CAPTURE);
    w_status_nxt[ADDR_W:0]       = w_count_nxt;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_status <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_we     <= w_we_nxt;
      r_status <= w_status_nxt;
      if (w_we_nxt) begin
        r_addr <= r_count[ADDR_W-1:0];
        r_data <= din_data;
      end
    end
  end

  assign bram_we     = r_we;
  assign bram_addr   = r_addr;
  assign bram_data   = r_data;
  assign status_word = r_status;

endmodule

// File: tb/tb_tge_tx_snapshot_ctrl.sv
// Directed bench for tge_tx_snapshot_ctrl with a 16-word buffer: a vector
// table for the free-running capture plus hand-written corner-case sequences.
module tb_tge_tx_snapshot_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;

  typedef struct {
    logic [31:0] ctrl;
    logic        trig;
    logic        valid;
    logic [63:0] data;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [63:0] exp_data;
    logic [31:0] exp_status;
  } vec_t;

  logic              user_clk = 1'b0;
  logic              user_rst_n;
  logic [31:0]       ctrl_word;
  logic              trig;
  logic              din_valid;
  logic [DATA_W-1:0] din_data;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic [31:0]       status_word;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          wr;
  logic [63:0] d_sent;
  logic [31:0] exp_st;
  vec_t        fr_tab[19];

  tge_tx_snapshot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .ctrl_word   (ctrl_word),
    .trig        (trig),
    .din_valid   (din_valid),
    .din_data    (din_data),
    .bram_we     (bram_we),
    .bram_addr   (bram_addr),
    .bram_data   (bram_data),
    .status_word (status_word)
  );

  always #5 user_clk = ~user_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [31:0] c, input logic t, input logic v, input logic [63:0] d);
    ctrl_word = c;
    trig      = t;
    din_valid = v;
    din_data  = d;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    drive(v.ctrl, v.trig, v.valid, v.data);
    step();
    check({tag, " we"}, 64'(bram_we), 64'(v.exp_we));
    if (v.exp_we) begin
      check({tag, " addr"}, 64'(bram_addr), 64'(v.exp_addr));
      check({tag, " data"}, bram_data, v.exp_data);
    end
    check({tag, " status"}, 64'(status_word), 64'(v.exp_status));
  endtask

  initial begin
    // Free run: ctrl 0x6 then 0x7 (immediate trigger, every cycle valid).
    fr_tab[0] = '{32'h6, 1'b0, 1'b0, 64'h0, 1'b0, 4'd0, 64'h0, 32'h0000_0000};
    fr_tab[1] = '{32'h7, 1'b0, 1'b0, 64'h0, 1'b0, 4'd0, 64'h0, 32'h4000_0000};
    for (int k = 0; k < 16; k++) begin
      fr_tab[2+k] = '{32'h7, 1'b0, 1'b0, 64'hA500_0000 + 64'(k), 1'b1, 4'(k),
                      64'hA500_0000 + 64'(k),
                      (k == 15) ? 32'h8000_0010 : (32'h2000_0000 | 32'(k + 1))};
    end
    fr_tab[18] = '{32'h7, 1'b0, 1'b0, 64'h0, 1'b0, 4'd0, 64'h0, 32'h8000_0010};

    user_rst_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 64'h0);
    repeat (3) step();
    check("reset we", 64'(bram_we), 64'h0);
    check("reset addr", 64'(bram_addr), 64'h0);
    check("reset data", bram_data, 64'h0);
    check("reset status", 64'(status_word), 64'h0);
    user_rst_n = 1'b1;

    for (int i = 0; i < 19; i++) apply_vec(fr_tab[i], $sformatf("free[%0d]", i));

    // Arm edge together with abort: abort wins, count kept, done cleared.
    drive(32'h0, 1'b0, 1'b0, 64'h0);
    step();
    check("simul pre status", 64'(status_word), 64'h8000_0010);
    drive(32'h9, 1'b0, 1'b0, 64'h0);
    step();
    check("simul we", 64'(bram_we), 64'h0);
    check("simul status", 64'(status_word), 64'h0000_0010);

    // External trigger with alternating din_valid; data = cycle number.
    drive(32'h0, 1'b0, 1'b0, 64'h0);
    step();
    drive(32'h1, 1'b0, 1'b0, 64'h0);
    step();
    check("ext arm status", 64'(status_word), 64'h4000_0000);
    for (int j = 0; j < 4; j++) begin
      drive(32'h1, 1'b0, 1'(j % 2), 64'(cyc));
      step();
      check("ext wait we", 64'(bram_we), 64'h0);
      check("ext wait status", 64'(status_word), 64'h4000_0000);
    end
    wr = 0;
    for (int j = 0; (wr < 16) && (j < 64); j++) begin
      drive(32'h1, (j == 0), (j % 2 == 0), 64'(cyc));
      d_sent = din_data;
      step();
      check("ext we", 64'(bram_we), 64'(din_valid));
      if (din_valid) begin
        check("ext addr", 64'(bram_addr), 64'(wr));
        check("ext data", bram_data, d_sent);
        wr++;
      end
      exp_st = (wr == 16) ? 32'h8000_0010 : (32'h2000_0000 | 32'(wr));
      check("ext status", 64'(status_word), 64'(exp_st));
    end
    check("ext write count", 64'(wr), 64'd16);
    drive(32'h1, 1'b1, 1'b1, 64'hDEAD);
    step();
    check("done trig we", 64'(bram_we), 64'h0);
    check("done trig status", 64'(status_word), 64'h8000_0010);

    // Arm edge in DONE, then a second arm edge mid-capture is ignored.
    drive(32'h0, 1'b0, 1'b0, 64'h0);
    step();
    drive(32'h1, 1'b0, 1'b0, 64'h0);
    step();
    check("rearm done status", 64'(status_word), 64'h4000_0000);
    for (int k = 0; k < 16; k++) begin
      drive((k == 3) ? 32'h0 : 32'h1, (k == 0), 1'b1, 64'hB000 + 64'(k));
      step();
      check("ign we", 64'(bram_we), 64'h1);
      check("ign addr", 64'(bram_addr), 64'(k));
      check("ign data", bram_data, 64'hB000 + 64'(k));
      exp_st = (k == 15) ? 32'h8000_0010 : (32'h2000_0000 | 32'(k + 1));
      check("ign status", 64'(status_word), 64'(exp_st));
    end
    drive(32'h1, 1'b0, 1'b1, 64'h0);
    step();
    check("ign tail we", 64'(bram_we), 64'h0);

    // Abort after five writes, trig ignored in IDLE, re-arm clears count.
    drive(32'h0, 1'b0, 1'b0, 64'h0);
    step();
    drive(32'h7, 1'b0, 1'b0, 64'h0);
    step();
    check("abort arm status", 64'(status_word), 64'h4000_0000);
    for (int k = 0; k < 5; k++) begin
      drive(32'h7, 1'b0, 1'b0, 64'hC000 + 64'(k));
      step();
      check("abort pre addr", 64'(bram_addr), 64'(k));
      check("abort pre we", 64'(bram_we), 64'h1);
    end
    drive(32'hF, 1'b0, 1'b1, 64'hEEEE);
    step();
    check("abort we", 64'(bram_we), 64'h0);
    check("abort status", 64'(status_word), 64'h0000_0005);
    drive(32'h0, 1'b1, 1'b1, 64'hEEEE);
    step();
    check("idle trig we", 64'(bram_we), 64'h0);
    check("idle trig status", 64'(status_word), 64'h0000_0005);
    drive(32'h1, 1'b0, 1'b0, 64'h0);
    step();
    check("abort rearm status", 64'(status_word), 64'h4000_0000);

    // Asynchronous reset mid-capture with the arm bit held high throughout.
    drive(32'h3, 1'b0, 1'b1, 64'h1111);
    step();
    check("rst pre addr0", 64'(bram_addr), 64'h0);
    drive(32'h3, 1'b0, 1'b1, 64'h2222);
    step();
    check("rst pre we", 64'(bram_we), 64'h1);
    #3;
    user_rst_n = 1'b0;
    #1;
    check("async rst we", 64'(bram_we), 64'h0);
    check("async rst addr", 64'(bram_addr), 64'h0);
    check("async rst data", bram_data, 64'h0);
    check("async rst status", 64'(status_word), 64'h0);
    step();
    user_rst_n = 1'b1;
    repeat (2) begin
      step();
      check("post rst we", 64'(bram_we), 64'h0);
      check("post rst status", 64'(status_word), 64'h0);
    end
    drive(32'h2, 1'b0, 1'b1, 64'h0);
    step();
    drive(32'h3, 1'b0, 1'b1, 64'h0);
    step();
    check("fresh arm status", 64'(status_word), 64'h4000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
